// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states, next-PC select codes
// and the default memory-wait timeout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StExc     = 2'd2
    } state_e;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_EXC = 2'd2;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// Memory-wait cycle counter; expired_o flags that the current wait cycle is number Limit.
module wait_timer #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic incr_i,
    output logic expired_o
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'((Limit > 0) ? Limit - 1 : 0);

    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of wait cycles already completed
    assign expired_o = (cnt_q >= LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (incr_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch and exception flushes,
// memory-wait stalls with timeout, and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_wraddr_i,
    input  logic             br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             exc_req_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic [1:0]       pc_sel_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             tmr_clear, tmr_incr, tmr_expired;
    logic             load_use;

    wait_timer #(
        .Limit (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (tmr_clear),
        .incr_i    (tmr_incr),
        .expired_o (tmr_expired)
    );

    assign load_use = ex_memread_i && (ex_wraddr_i != 5'd0) &&
                      ((ex_wraddr_i == id_rs_i) || (ex_wraddr_i == id_rt_i));

    always_comb begin
        state_d       = state_q;
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        idex_en_o     = 1'b1;
        exmem_en_o    = 1'b1;
        memwb_en_o    = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        pc_sel_o      = SEL_SEQ;
        bus_err_o     = 1'b0;
        tmr_clear     = 1'b1;
        tmr_incr      = 1'b0;

        case (state_q)
            StRun: begin
                if (exc_req_i) begin
                    pc_sel_o      = SEL_EXC;
                    ifid_flush_o  = 1'b1;
                    idex_flush_o  = 1'b1;
                    exmem_flush_o = 1'b1;
                    state_d       = StExc;
                end else if (mem_req_i && !mem_ready_i) begin
                    {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o} = '0;
                    tmr_clear = 1'b0;
                    tmr_incr  = 1'b1;
                    state_d   = StMemWait;
                end else if (br_taken_i) begin
                    pc_sel_o     = SEL_BR;
                    ifid_flush_o = 1'b1;
                    idex_flush_o = 1'b1;
                end else if (load_use) begin
                    pc_en_o      = 1'b0;
                    ifid_en_o    = 1'b0;
                    idex_flush_o = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ready_i) begin
                    state_d = StRun;
                end else if (tmr_expired) begin
                    bus_err_o     = 1'b1;
                    pc_sel_o      = SEL_EXC;
                    ifid_flush_o  = 1'b1;
                    idex_flush_o  = 1'b1;
                    exmem_flush_o = 1'b1;
                    state_d       = StExc;
                end else begin
                    {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o} = '0;
                    tmr_clear = 1'b0;
                    tmr_incr  = 1'b1;
                end
            end
            StExc: begin
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
                state_d       = StRun;
            end
            default: state_d = StRun;
        endcase

        // Outputs are forced quiet for as long as reset is held, not just at the edge
        if (!rst_ni) begin
            {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o} = '0;
            {ifid_flush_o, idex_flush_o, exmem_flush_o}             = '0;
            pc_sel_o  = SEL_SEQ;
            bus_err_o = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed test of pipe_ctrl with TIMEOUT=4 and a 4-bit stall counter.
module tb_pipe_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [4:0]    id_rs_i, id_rt_i, ex_wraddr_i;
    logic          ex_memread_i, br_taken_i, mem_req_i, mem_ready_i, exc_req_i;
    logic          pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
    logic          ifid_flush_o, idex_flush_o, exmem_flush_o;
    logic [1:0]    pc_sel_o, state_o;
    logic          bus_err_o;
    logic [CW-1:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl #(
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .ex_memread_i  (ex_memread_i),
        .ex_wraddr_i   (ex_wraddr_i),
        .br_taken_i    (br_taken_i),
        .mem_req_i     (mem_req_i),
        .mem_ready_i   (mem_ready_i),
        .exc_req_i     (exc_req_i),
        .pc_en_o       (pc_en_o),
        .ifid_en_o     (ifid_en_o),
        .idex_en_o     (idex_en_o),
        .exmem_en_o    (exmem_en_o),
        .memwb_en_o    (memwb_en_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_flush_o  (idex_flush_o),
        .exmem_flush_o (exmem_flush_o),
        .pc_sel_o      (pc_sel_o),
        .bus_err_o     (bus_err_o),
        .stall_cnt_o   (stall_cnt_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    wire [4:0] en = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o};
    wire [2:0] fl = {ifid_flush_o, idex_flush_o, exmem_flush_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic drive(input logic lr, input logic [4:0] wa, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic mreq,
                         input logic mrdy, input logic exc);
        ex_memread_i = lr;
        ex_wraddr_i  = wa;
        id_rs_i      = rs;
        id_rt_i      = rt;
        br_taken_i   = br;
        mem_req_i    = mreq;
        mem_ready_i  = mrdy;
        exc_req_i    = exc;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b1;
        idle();
        #1 rst_ni = 1'b0;
        cyc();
        cyc();
        check("rst_en", 32'(en), 32'h00);
        check("rst_fl", 32'(fl), 32'h0);
        check("rst_sel", 32'(pc_sel_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_stall", 32'(stall_cnt_o), 32'd0);
        check("rst_buserr", 32'(bus_err_o), 32'd0);
        rst_ni = 1'b1;
        cyc();

        // first cycle out of reset: free-running
        idle();
        check("idle_en", 32'(en), 32'h1f);
        check("idle_fl", 32'(fl), 32'h0);
        check("idle_sel", 32'(pc_sel_o), 32'd0);
        cyc();

        // load-use on rs
        drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_rs_en", 32'(en), 32'h07);
        check("lu_rs_fl", 32'(fl), 32'h2);
        check("lu_rs_sel", 32'(pc_sel_o), 32'd0);
        cyc();
        check("lu_rs_stall", 32'(stall_cnt_o), 32'd1);
        check("lu_rs_state", 32'(state_o), 32'd0);

        // load to r0 never interlocks
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_r0_en", 32'(en), 32'h1f);
        check("lu_r0_fl", 32'(fl), 32'h0);
        cyc();
        check("lu_r0_stall", 32'(stall_cnt_o), 32'd1);

        // non-load with matching register: no interlock
        drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        check("nolu_en", 32'(en), 32'h1f);
        cyc();

        // load-use on rt
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_rt_en", 32'(en), 32'h07);
        cyc();
        check("lu_rt_stall", 32'(stall_cnt_o), 32'd2);

        // branch wins over load-use
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("br_sel", 32'(pc_sel_o), 32'd1);
        check("br_fl", 32'(fl), 32'h6);
        check("br_en", 32'(en), 32'h1f);
        cyc();
        check("br_stall", 32'(stall_cnt_o), 32'd2);

        // exception wins over memory wait; EXC drains one cycle with exc_req masked
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("exc_sel", 32'(pc_sel_o), 32'd2);
        check("exc_fl", 32'(fl), 32'h7);
        check("exc_en", 32'(en), 32'h1f);
        check("exc_buserr", 32'(bus_err_o), 32'd0);
        cyc();
        check("exc_state", 32'(state_o), 32'd2);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_en", 32'(en), 32'h1f);
        check("drain_fl", 32'(fl), 32'h3);
        check("drain_sel", 32'(pc_sel_o), 32'd0);
        cyc();
        check("drain_state", 32'(state_o), 32'd0);

        // memory wait: ready low for 3 cycles then high
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mw1_en", 32'(en), 32'h00);
        check("mw1_fl", 32'(fl), 32'h0);
        cyc();
        check("mw1_state", 32'(state_o), 32'd1);
        check("mw2_en", 32'(en), 32'h00);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("mw3_exc_ignored_en", 32'(en), 32'h00);
        check("mw3_exc_ignored_sel", 32'(pc_sel_o), 32'd0);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("mw4_en", 32'(en), 32'h1f);
        check("mw4_buserr", 32'(bus_err_o), 32'd0);
        cyc();
        check("mw_done_state", 32'(state_o), 32'd0);
        check("mw_done_stall", 32'(stall_cnt_o), 32'd5);

        // timeout: bus error on the 4th wait cycle
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("to_wait%0d_en", i), 32'(en), 32'h00);
            check($sformatf("to_wait%0d_buserr", i), 32'(bus_err_o), 32'd0);
            cyc();
        end
        check("to_buserr", 32'(bus_err_o), 32'd1);
        check("to_sel", 32'(pc_sel_o), 32'd2);
        check("to_fl", 32'(fl), 32'h7);
        check("to_en", 32'(en), 32'h1f);
        cyc();
        check("to_exc_state", 32'(state_o), 32'd2);
        check("to_exc_buserr", 32'(bus_err_o), 32'd0);
        check("to_stall", 32'(stall_cnt_o), 32'd8);
        cyc();
        check("to_run_state", 32'(state_o), 32'd0);

        // stall counter saturates at all-ones
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc();
        check("sat_reach", 32'(stall_cnt_o), 32'd15);
        for (int i = 0; i < 3; i++) cyc();
        check("sat_hold", 32'(stall_cnt_o), 32'd15);

        // reset during EXC
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        check("rexc_state_pre", 32'(state_o), 32'd2);
        rst_ni = 1'b0;
        #1;
        check("rexc_state", 32'(state_o), 32'd0);
        check("rexc_en", 32'(en), 32'h00);
        check("rexc_fl", 32'(fl), 32'h0);
        check("rexc_buserr", 32'(bus_err_o), 32'd0);
        cyc();
        check("rexc_en_held", 32'(en), 32'h00);
        rst_ni = 1'b1;
        idle();
        cyc();
        check("rexc_stall_after", 32'(stall_cnt_o), 32'd0);
        check("rexc_state_after", 32'(state_o), 32'd0);
        check("rexc_en_after", 32'(en), 32'h1f);

        // reset during MEMWAIT clears the wait counter
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        check("rmw_state_pre", 32'(state_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rmw_state", 32'(state_o), 32'd0);
        check("rmw_buserr", 32'(bus_err_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        #1;
        cyc();
        cyc();
        check("rmw_wait3_state", 32'(state_o), 32'd1);
        check("rmw_wait3_buserr", 32'(bus_err_o), 32'd0);
        check("rmw_wait3_en", 32'(en), 32'h00);
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum memory-wait cycles before a bus error is declared.
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 ex_memread  in  1  instruction in EX is a load.
REQ-007 ex_wraddr  in  5  destination register of the instruction in EX.
REQ-008 br_taken  in  1  EX resolved a taken branch or jump.
REQ-009 mem_req  in  1  MEM stage holds a load or store.
REQ-010 mem_ready  in  1  data memory completes the access this cycle.
REQ-011 exc_req  in  1  exception or interrupt raised at MEM.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  load enables for the PC and the pipeline registers.
REQ-013 ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that register on the next edge.
REQ-014 pc_sel  out  2  next-PC select: 0 sequential, 1 branch target, 2 exception vector.
REQ-015 bus_err  out  1  one-cycle pulse when a memory wait times out.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.
REQ-017 state  out  2  current FSM state, for debug.

Function
REQ-018 FSM states: RUN, MEMWAIT, EXC.
REQ-019 Default outputs in RUN with no events: all enables 1, all flushes 0, pc_sel=0.
REQ-020 Event priority, highest first: exception, then memory wait, then taken branch, then load-use.
REQ-021 RUN, exc_req=1:
 - same-cycle outputs: pc_sel=2; ifid_flush, idex_flush and exmem_flush all 1; all enables 1.
 - next state EXC.
REQ-022 RUN, mem_req=1, mem_ready=0, exc_req=0:
 - same cycle: all five enables 0, flushes 0.
 - next state MEMWAIT; wait counter loads 1.
REQ-023 MEMWAIT, mem_ready=0: all enables 0; wait counter increments.
REQ-024 MEMWAIT, mem_ready=1: all enables 1; next state RUN; counter clears.
REQ-025 MEMWAIT timeout (counter reaches TIMEOUT with mem_ready=0):
 - bus_err=1 for exactly one cycle.
 - outputs as REQ-021; next state EXC.
REQ-026 exc_req is ignored in MEMWAIT.
REQ-027 RUN, br_taken=1 (no higher event): pc_sel=1; ifid_flush and idex_flush 1; enables 1.
REQ-028 RUN, load-use (no higher event):
 - condition: ex_memread=1, ex_wraddr!=0, and ex_wraddr equals id_rs or id_rt.
 - response: pc_en=0, ifid_en=0, idex_flush=1, other enables 1; exactly one bubble.
REQ-029 Branch and load-use in the same cycle: branch response only.
REQ-030 EXC (one drain cycle):
 - all enables 1; idex_flush and exmem_flush 1; exc_req masked.
 - next state RUN unconditionally.
REQ-031 stall_cnt:
 - increments on every cycle with pc_en=0.
 - holds at all-ones; never wraps.
REQ-032 All outputs are combinational from state and inputs, except state, stall_cnt and the wait counter.

Reset
REQ-033 While reset=0:
 - state=RUN; wait counter 0; stall_cnt 0; bus_err 0.
 - all enables and flushes 0; pc_sel 0.
REQ-034 Reset asserted mid-MEMWAIT or mid-EXC: immediate return to RUN values; no bus_err pulse.
REQ-035 First edge after reset release: REQ-019 behaviour.

Structure
REQ-036 Package pipe_ctrl_pkg holds: the state encoding, the pc_sel codes (SEL_SEQ, SEL_BR, SEL_EXC), and the TIMEOUT default.
REQ-037 One sub-module, wait_timer, implements the wait counter:
 - inputs: clear, increment.
 - output: expired.

Verification
REQ-038 ex_memread=1, ex_wraddr=5, id_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 for that cycle; stall_cnt=1.
REQ-039 ex_wraddr=0 with a load and id_rt=0 -> no stall.
REQ-040 br_taken=1 together with a load-use hit -> pc_sel=1, ifid_flush=idex_flush=1, pc_en=1.
REQ-041 mem_req=1, mem_ready low for 3 cycles then high -> enables 0 for 3 cycles, 1 on the 4th; state returns RUN; stall_cnt=3.
REQ-042 mem_ready held low with TIMEOUT=4 -> bus_err pulse on 4th wait cycle, pc_sel=2, EXC next cycle, RUN after.
REQ-043 exc_req=1 in RUN, reset dropped during the EXC cycle -> state=RUN; all enables 0 while reset=0; stall_cnt=0 after release.
